uart_receiver: RTL

- Serial-to-parallel UART receiver; the receive-side counterpart of the team's 8N1 transmitter.
- Fixed 8N1 frame: start bit 0, 8 data bits LSB first, one stop bit 1.
- Synchronises the asynchronous rx line, validates start and stop bits, and presents each byte on a level-held ready/ack handshake with framing and overrun flags.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/sync_2ff.sv | 31 +++
 rtl/uart_receiver.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART frame constants, receiver state encoding and bit-period helper
package uart_pkg;

    // Data bits carried by one 8N1 frame.
    localparam int FRAME_DATA_BITS = 8;

    // Bit-period counter width; 17 bits holds 16'hFFFF + 3 without wrapping.
    localparam int CNT_W = 17;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_HIGH = 3'd4
    } rx_state_e;

    // One bit period in clocks. Transmitter and receiver both derive their
    // timing from this, so the two ends cannot disagree on the formula.
    function automatic logic [CNT_W-1:0] bit_period(input logic [15:0] bit_rate_val);
        return CNT_W'(bit_rate_val) + CNT_W'(3);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - 1-bit two-flop synchroniser, resets to 1
// Ports:
//   clk - system clock
//   res - synchronous active-high reset
//   d_i - asynchronous input
//   q_o - input synchronised to clk, two clocks of latency
module sync_2ff (
    input  logic clk,
    input  logic res,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Reset value 1 matches an idle-high serial line, so leaving reset never
    // looks like a falling edge.
    always_ff @(posedge clk) begin
        if (res) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - 8N1 UART receiver with level ready/ack byte handshake
// Ports:
//   clk  - system clock, all logic on the rising edge
//   res  - synchronous active-high reset
//   rx   - asynchronous serial line, idle high
//   ack  - consumer acknowledge; clears drdy and ovr
//   dout - last received byte, stable while drdy=1
//   drdy - a valid byte is waiting in dout
//   ferr - one-cycle pulse when the stop bit is sampled low
//   ovr  - sticky: a new byte overwrote an unacknowledged one
//   busy - high whenever the receiver is not idle
module uart_receiver
    import uart_pkg::*;
#(
    parameter logic [15:0] BIT_RATE_VAL = 16'h01B0
) (
    input  logic       clk,
    input  logic       res,
    input  logic       rx,
    input  logic       ack,
    output logic [7:0] dout,
    output logic       drdy,
    output logic       ferr,
    output logic       ovr,
    output logic       busy
);

    localparam logic [CNT_W-1:0] PERIOD   = bit_period(BIT_RATE_VAL);
    localparam logic [CNT_W-1:0] HALF     = PERIOD >> 1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [2:0]       LAST_BIT = 3'(FRAME_DATA_BITS - 1);

    logic                       rx_s;
    rx_state_e                  state_q;
    rx_state_e                  state_d;
    logic [CNT_W-1:0]           cnt_q;
    logic [CNT_W-1:0]           cnt_d;
    logic [2:0]                 bit_idx_q;
    logic [2:0]                 bit_idx_d;
    logic [FRAME_DATA_BITS-1:0] shift_q;
    logic [FRAME_DATA_BITS-1:0] shift_d;
    logic [7:0]                 dout_q;
    logic                       drdy_q;
    logic                       ferr_q;
    logic                       ovr_q;
    logic                       busy_c;
    logic                       start_hit;
    logic                       bit_hit;
    logic                       load_byte;
    logic                       frame_err;

    sync_2ff u_rx_sync (
        .clk (clk),
        .res (res),
        .d_i (rx),
        .q_o (rx_s)
    );

    // The counter holds 1 on the first cycle after each reference point, so a
    // count equal to HALF (or PERIOD) lands exactly HALF (or PERIOD) cycles
    // after the falling edge was seen (or after the previous sample).
    assign start_hit = (cnt_q == HALF);
    assign bit_hit   = (cnt_q == PERIOD);

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk) begin
        if (res) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (!rx_s) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                // High at mid start bit means the low was a glitch.
                if (start_hit) begin
                    state_d = rx_s ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_hit && (bit_idx_q == LAST_BIT)) begin
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (bit_hit) begin
                    state_d = rx_s ? ST_IDLE : ST_WAIT_HIGH;
                end
            end
            ST_WAIT_HIGH: begin
                // A held-low line (break) must return high before the next
                // frame can start.
                if (rx_s) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------- outputs
    always_comb begin
        busy_c    = 1'b1;
        cnt_d     = cnt_q + CNT_ONE;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        load_byte = 1'b0;
        frame_err = 1'b0;
        case (state_q)
            ST_IDLE: begin
                busy_c = 1'b0;
                cnt_d  = rx_s ? '0 : CNT_ONE;
            end
            ST_START: begin
                if (start_hit) begin
                    cnt_d     = CNT_ONE;
                    bit_idx_d = 3'd0;
                end
            end
            ST_DATA: begin
                if (bit_hit) begin
                    cnt_d     = CNT_ONE;
                    shift_d   = {rx_s, shift_q[FRAME_DATA_BITS-1:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                end
            end
            ST_STOP: begin
                if (bit_hit) begin
                    cnt_d     = '0;
                    load_byte = rx_s;
                    frame_err = !rx_s;
                end
            end
            ST_WAIT_HIGH: begin
                cnt_d = '0;
            end
            default: begin
                cnt_d = '0;
            end
        endcase
    end

    // ------------------------------------------------------------- datapath
    always_ff @(posedge clk) begin
        if (res) begin
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
        end else begin
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
        end
    end

    // A load wins over a plain ack: the new byte stays ready. The overrun flag
    // only sets when the previous byte was still unacknowledged in that cycle.
    always_ff @(posedge clk) begin
        if (res) begin
            dout_q <= 8'h00;
            drdy_q <= 1'b0;
            ferr_q <= 1'b0;
            ovr_q  <= 1'b0;
        end else begin
            ferr_q <= frame_err;
            if (load_byte) begin
                dout_q <= shift_q;
                drdy_q <= 1'b1;
                ovr_q  <= drdy_q && !ack;
            end else if (ack && drdy_q) begin
                drdy_q <= 1'b0;
                ovr_q  <= 1'b0;
            end
        end
    end

    assign dout = dout_q;
    assign drdy = drdy_q;
    assign ferr = ferr_q;
    assign ovr  = ovr_q;
    assign busy = busy_c;

endmodule
